// File: rtl/mbe_seq_mul_ctrl.sv
// Iterative unsigned NBIT x NBIT multiplier, one radix-4 Booth digit per clock.
// Optional macro MBE_EARLY_TERM_EN: finish early once the remaining multiplier bits are all zero.
module mbe_seq_mul_ctrl #(
  parameter int unsigned NBIT = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NBIT-1:0]   a,
  input  logic [NBIT-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*NBIT-1:0] product,
  output logic              busy
);

  localparam int unsigned NDIG = NBIT / 2 + 1;
  localparam int unsigned BW   = 2 * NDIG + 1;
  localparam int unsigned AW   = 2 * NBIT + 3;
  localparam int unsigned PW   = 2 * NBIT;
  localparam int unsigned CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_e;

  state_e          state_q, state_d;
  logic [NBIT-1:0] a_q, a_d;
  logic [BW-1:0]   b_q, b_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   digit_q, digit_d;
  logic [PW-1:0]   product_q, product_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;

  logic [CW:0]     bit_idx;
  logic [2:0]      trip;
  logic [AW-1:0]   a_ext;
  logic [AW-1:0]   pp;
  logic [AW-1:0]   sum;
  logic            last_dig;
  logic            rest_zero;

  // Booth digit selection and two's-complement partial product
  always_comb begin
    bit_idx  = {digit_q, 1'b0};
    trip     = 3'(b_q >> bit_idx);
    a_ext    = AW'(a_q);
    last_dig = (digit_q == CW'(NDIG - 1));
    unique case (trip)
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = a_ext << 1;
      3'b100:         pp = AW'(0) - (a_ext << 1);
      3'b101, 3'b110: pp = AW'(0) - a_ext;
      default:        pp = '0;
    endcase
    sum = acc_q + (pp << bit_idx);
`ifdef MBE_EARLY_TERM_EN
    // Bit 2*digit is the low bit of the current triplet, so it must be zero too
    rest_zero = ((b_q >> bit_idx) == '0);
`else
    rest_zero = 1'b0;
`endif
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    digit_d     = digit_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = BW'({b, 1'b0});
          acc_d      = '0;
          digit_d    = '0;
          state_d    = ST_CALC;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_CALC: begin
        if (rest_zero) begin
          state_d     = ST_DONE;
          product_d   = acc_q[PW-1:0];
          out_valid_d = 1'b1;
        end else begin
          acc_d   = sum;
          digit_d = digit_q + CW'(1);
          if (last_dig) begin
            state_d     = ST_DONE;
            product_d   = sum[PW-1:0];
            out_valid_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      digit_q     <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      digit_q     <= digit_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mbe_seq_mul_ctrl.sv
// Self-checking bench for mbe_seq_mul_ctrl: directed vector table, backpressure,
// mid-operation reset and a back-to-back random stream.
module tb_mbe_seq_mul_ctrl;

  localparam int unsigned NBIT = 11;
  localparam int unsigned NDIG = NBIT / 2 + 1;
  localparam int unsigned BW   = 2 * NDIG + 1;
  localparam int unsigned PW   = 2 * NBIT;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [NBIT-1:0] a;
  logic [NBIT-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [PW-1:0]   product;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  mbe_seq_mul_ctrl #(.NBIT(NBIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NBIT-1:0] a;
    logic [NBIT-1:0] b;
    int              hold;
    logic [PW-1:0]   exp_p;
    string           name;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Number of CALC cycles for a given multiplier
  function automatic int calc_cycles(input logic [NBIT-1:0] bv);
`ifdef MBE_EARLY_TERM_EN
    logic [BW-1:0] be;
    be = BW'({bv, 1'b0});
    for (int d = 0; d < int'(NDIG); d++)
      if ((be >> (2 * d)) == '0) return d + 1;
    return int'(NDIG);
`else
    return int'(NDIG);
`endif
  endfunction

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check({name, "_in_ready"}, 64'(in_ready), 64'(1));
  endtask

  // One full transaction; latency counts edges from the accept edge inclusive
  task automatic run_op(input vec_t v);
    int cyc;
    logic [PW-1:0] held;
    wait_ready(v.name);
    a         = v.a;
    b         = v.b;
    in_valid  = 1'b1;
    out_ready = (v.hold == 0);
    tick();
    in_valid = 1'b0;
    cyc      = 1;
    check({v.name, "_busy"}, 64'(busy), 64'(1));
    check({v.name, "_ready_low"}, 64'(in_ready), 64'(0));
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check({v.name, "_latency"}, 64'(cyc), 64'(calc_cycles(v.b) + 1));
    held = product;
    for (int i = 0; i < v.hold; i++) begin
      check({v.name, "_hold_valid"}, 64'(out_valid), 64'(1));
      check({v.name, "_hold_product"}, 64'(product), 64'(held));
      check({v.name, "_hold_in_ready"}, 64'(in_ready), 64'(0));
      tick();
    end
    out_ready = 1'b1;
    check({v.name, "_product"}, 64'(product), 64'(v.exp_p));
    tick();
    check({v.name, "_valid_drop"}, 64'(out_valid), 64'(0));
    check({v.name, "_idle"}, 64'(in_ready), 64'(1));
    check({v.name, "_busy_drop"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[9];
    vec_t v;
    logic [NBIT-1:0] qa[$];
    logic [NBIT-1:0] qb[$];
    logic [NBIT-1:0] last_b;
    int last_acc, n_acc, n_out;
    logic acc_now;

    vecs[0] = '{a: 11'd1234, b: 11'd567,  hold: 0,  exp_p: 22'd699678,  name: "v1234x567"};
    vecs[1] = '{a: 11'd2047, b: 11'd2047, hold: 0,  exp_p: 22'd4190209, name: "vmaxxmax"};
    vecs[2] = '{a: 11'h5A5,  b: 11'd0,    hold: 0,  exp_p: 22'd0,       name: "v5a5x0"};
    vecs[3] = '{a: 11'd0,    b: 11'd2047, hold: 0,  exp_p: 22'd0,       name: "v0xmax"};
    vecs[4] = '{a: 11'd3,    b: 11'd5,    hold: 10, exp_p: 22'd15,      name: "vbackpressure"};
    vecs[5] = '{a: 11'd1,    b: 11'd2,    hold: 0,  exp_p: 22'd2,       name: "v1x2"};
    vecs[6] = '{a: 11'd2047, b: 11'd1,    hold: 0,  exp_p: 22'd2047,    name: "vmaxx1"};
    vecs[7] = '{a: 11'd1365, b: 11'd682,  hold: 0,  exp_p: 22'd930930,  name: "valt"};
    vecs[8] = '{a: 11'd1024, b: 11'd1024, hold: 0,  exp_p: 22'd1048576, name: "vmsb"};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_product", 64'(product), 64'(0));
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_op(vecs[i]);

    // Asynchronous reset in the third CALC cycle discards the pending result
    wait_ready("midrst");
    a        = 11'd100;
    b        = 11'd200;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_product", 64'(product), 64'(0));
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("midrst_no_stale", 64'(out_valid), 64'(0));
      tick();
    end
    v = '{a: 11'd7, b: 11'd9, hold: 0, exp_p: 22'd63, name: "after_rst"};
    run_op(v);

    // Back-to-back stream with in_valid and out_ready held high
    last_acc  = -1;
    last_b    = '0;
    n_acc     = 0;
    n_out     = 0;
    out_ready = 1'b1;
    a         = NBIT'($urandom_range(0, 2047));
    b         = NBIT'($urandom_range(0, 2047));
    in_valid  = 1'b1;
    for (int c = 0; c < 400 && n_out < 20; c++) begin
      acc_now = 1'b0;
      if (out_valid) begin
        if (qa.size() > 0) begin
          check("b2b_product", 64'(product), 64'(PW'(qa[0]) * PW'(qb[0])));
          void'(qa.pop_front());
          void'(qb.pop_front());
        end else begin
          check("b2b_unexpected_valid", 64'(out_valid), 64'(0));
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        if (last_acc >= 0)
          check("b2b_period", 64'(c - last_acc), 64'(calc_cycles(last_b) + 2));
        qa.push_back(a);
        qb.push_back(b);
        last_acc = c;
        last_b   = b;
        n_acc++;
        acc_now  = 1'b1;
      end
      tick();
      if (acc_now) begin
        if (n_acc == 20) in_valid = 1'b0;
        else begin
          a = NBIT'($urandom_range(0, 2047));
          b = NBIT'($urandom_range(0, 2047));
        end
      end
    end
    check("b2b_outputs", 64'(n_out), 64'(20));
    check("b2b_accepts", 64'(n_acc), 64'(20));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
